// File: rtl/conversor_e3_seq.sv
// conversor_e3_seq: packed BCD to Excess-3 word converter, one shared digit converter, LSD first; define CONV_E3_CHECK_EN to flag and saturate digits above 9
module conversor_e3_digit (
  input  logic [3:0] bcd,
`ifdef CONV_E3_CHECK_EN
  output logic       bad,
`endif
  output logic [3:0] e3
);
`ifdef CONV_E3_CHECK_EN
  assign bad = bcd > 4'd9;
  assign e3  = bad ? 4'hF : bcd + 4'd3;
`else
  assign e3  = bcd + 4'd3;
`endif
endmodule

module conversor_e3_seq #(
  parameter int DIGITS = 4,
  parameter int DW     = 4 * DIGITS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [DW-1:0]                            din,
  output logic                                     busy,
  output logic                                     done,
  output logic [DW-1:0]                            dout,
  output logic                                     err,
  output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] idx
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [DW-1:0] src, acc, acc_nxt;
  logic [3:0] e3;
  logic last;
`ifdef CONV_E3_CHECK_EN
  logic bad, pend;
  conversor_e3_digit u_digit (.bcd(src[3:0]), .bad(bad), .e3(e3));
`else
  conversor_e3_digit u_digit (.bcd(src[3:0]), .e3(e3));
  assign err = 1'b0;
`endif
  assign last = idx == IW'(DIGITS - 1);
  always_comb begin
    acc_nxt = acc;
    acc_nxt[4*idx +: 4] = e3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      idx   <= '0;
      src   <= '0;
      acc   <= '0;
`ifdef CONV_E3_CHECK_EN
      err   <= 1'b0;
      pend  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          src   <= din;
          acc   <= '0;
          idx   <= '0;
          busy  <= 1'b1;
          state <= CONV;
`ifdef CONV_E3_CHECK_EN
          pend  <= 1'b0;
`endif
        end
        CONV: begin
          src <= src >> 4;
          acc <= acc_nxt;
`ifdef CONV_E3_CHECK_EN
          pend <= pend | bad;
`endif
          if (last) begin
            dout  <= acc_nxt;
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
`ifdef CONV_E3_CHECK_EN
            err   <= pend | bad;
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conversor_e3_seq.sv
// tb_conversor_e3_seq: randomized and directed checks of conversor_e3_seq at DIGITS 1, 4 and 8 against a digit-wise model
module tb_conversor_e3_seq;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_v;
  logic [31:0] din_v [3];
  wire [2:0] busy_v, done_v, err_v;
  wire [31:0] dout_v [3];
  wire [31:0] idx_v [3];
  logic [3:0] dout1;
  logic [15:0] dout4;
  logic [31:0] dout8;
  logic idx1;
  logic [1:0] idx4;
  logic [2:0] idx8;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conversor_e3_seq #(.DIGITS(1)) u_d1 (.clk(clk), .rst(rst), .start(start_v[0]), .din(din_v[0][3:0]),
    .busy(busy_v[0]), .done(done_v[0]), .dout(dout1), .err(err_v[0]), .idx(idx1));
  conversor_e3_seq #(.DIGITS(4)) u_d4 (.clk(clk), .rst(rst), .start(start_v[1]), .din(din_v[1][15:0]),
    .busy(busy_v[1]), .done(done_v[1]), .dout(dout4), .err(err_v[1]), .idx(idx4));
  conversor_e3_seq #(.DIGITS(8)) u_d8 (.clk(clk), .rst(rst), .start(start_v[2]), .din(din_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .dout(dout8), .err(err_v[2]), .idx(idx8));

  assign dout_v[0] = {28'b0, dout1};
  assign dout_v[1] = {16'b0, dout4};
  assign dout_v[2] = dout8;
  assign idx_v[0] = {31'b0, idx1};
  assign idx_v[1] = {30'b0, idx4};
  assign idx_v[2] = {29'b0, idx8};

  function automatic int nd(input int k);
    return k == 0 ? 1 : k == 1 ? 4 : 8;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w, input int n, output logic e);
    logic [31:0] r;
    r = 0;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = int'((w >> (4 * i)) & 32'hF);
`ifdef CONV_E3_CHECK_EN
      if (d > 9) begin
        e = 1'b1;
        d = 12;
      end
`endif
      r = r | (32'((d + 3) % 16) << (4 * i));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic conv(input int k, input logic [31:0] w, output logic [31:0] got, output logic gerr);
    int n, c;
    logic [31:0] m;
    logic e;
    n = nd(k);
    m = model(w, n, e);
    din_v[k] = w;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check("busy_rise", 32'(busy_v[k]), 1);
    c = 1;
    while (!done_v[k] && c <= n + 3) begin
      check("idx", idx_v[k], 32'(c - 1));
      @(negedge clk);
      c++;
    end
    check("latency", 32'(c), 32'(n + 1));
    check("dout", dout_v[k], m);
    check("err", 32'(err_v[k]), 32'(e));
    check("busy_in_done", 32'(busy_v[k]), 1);
    got = dout_v[k];
    gerr = err_v[k];
    @(negedge clk);
    check("done_single", 32'(done_v[k]), 0);
    check("busy_fall", 32'(busy_v[k]), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic ge;
    int cnt, last;
    rst = 1'b1;
    start_v = '0;
    for (int k = 0; k < 3; k++) din_v[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", 32'(busy_v[k]), 0);
      check("rst_done", 32'(done_v[k]), 0);
      check("rst_dout", dout_v[k], 0);
      check("rst_err", 32'(err_v[k]), 0);
      check("rst_idx", idx_v[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    conv(1, 32'h1234, got, ge);
    check("basic", got, 32'h4567);
    conv(1, 32'h0099, got, ge);
    check("tbl_0099", got, 32'h33CC);
    repeat (3) @(negedge clk);
    check("dout_hold", dout_v[1], 32'h33CC);
    conv(1, 32'h5678, got, ge);
    check("tbl_5678", got, 32'h89AB);

    conv(1, 32'h9A00, got, ge);
`ifdef CONV_E3_CHECK_EN
    check("inv_dout", got, 32'hCF33);
    check("inv_err", 32'(ge), 1);
    repeat (2) @(negedge clk);
    check("err_hold", 32'(err_v[1]), 1);
`else
    check("inv_dout", got, 32'hCD33);
    check("inv_err", 32'(ge), 0);
`endif
    conv(1, 32'h0000, got, ge);
    check("zero_dout", got, 32'h3333);
    check("zero_err", 32'(ge), 0);

    din_v[1] = 32'h1111;
    start_v[1] = 1'b1;
    cnt = 0;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[1]) begin
        cnt++;
        check("hold_dout", dout_v[1], 32'h4444);
        if (last >= 0) check("hold_gap", 32'(i - last), 6);
        last = i;
      end
    end
    start_v[1] = 1'b0;
    check("hold_count", 32'(cnt), 3);
    repeat (8) @(negedge clk);
    check("hold_drain", 32'(busy_v[1]), 0);

    din_v[1] = 32'h2222;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    din_v[1] = 32'h9999;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("pulse_done", 32'(done_v[1]), 1);
    check("pulse_dout", dout_v[1], 32'h5555);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    check("pulse_idle", 32'(busy_v[1]), 0);
    @(negedge clk);
    check("pulse_noextra", 32'(busy_v[1] | done_v[1]), 0);

    din_v[1] = 32'h4321;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy_v[1]), 0);
    check("abort_dout", dout_v[1], 0);
    check("abort_err", 32'(err_v[1]), 0);
    check("abort_idx", idx_v[1], 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[1]) cnt++;
    end
    check("abort_nodone", 32'(cnt), 0);
    conv(1, 32'h0002, got, ge);
    check("after_abort", got, 32'h3335);

    conv(0, 32'h7, got, ge);
    check("d1_7", got, 32'hA);
    conv(2, 32'h98765432, got, ge);
    check("d8_word", got, 32'hCBA98765);

    for (int i = 0; i < 12; i++) conv(1, $urandom() & 32'hFFFF, got, ge);
    for (int i = 0; i < 4; i++) conv(0, $urandom() & 32'hF, got, ge);
    for (int i = 0; i < 4; i++) conv(2, $urandom(), got, ge);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
